// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_pkg;

  localparam int          ADDR_WIDTH_DEF = 14;
  localparam logic [31:0] NOP_WORD_DEF   = 32'h0000_0013;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Source of the instruction output register
  typedef enum logic [1:0] {
    OSEL_ZERO = 2'd0,  // reset value
    OSEL_RAM  = 2'd1,  // registered RAM read
    OSEL_NOP  = 2'd2   // fetch stalled
  } osel_t;

endpackage

// File: rtl/imem_loader_if.sv
// Fetch/loader-side bundle of the instruction memory.
// Latency: n/a (wiring only).
// Backpressure: none; byte_valid is a strobe, fetch is held off by fetch_stall.
// master: fetch stage + program loader; slave: imem_loader.
interface imem_loader_if
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
  logic [31:0]         pc;
  logic [31:0]         instruction;
  logic                pc_misaligned;
  logic                fetch_stall;
  logic                load_mode;
  logic                byte_valid;
  logic [7:0]          byte_data;
  logic                load_done;
  logic                load_err;
  logic [ADDR_WIDTH:0] words_loaded;

  modport master (
    output pc, load_mode, byte_valid, byte_data,
    input  instruction, pc_misaligned, fetch_stall, load_done, load_err, words_loaded
  );

  modport slave (
    input  pc, load_mode, byte_valid, byte_data,
    output instruction, pc_misaligned, fetch_stall, load_done, load_err, words_loaded
  );
endinterface

// File: rtl/imem_ram.sv
// Single-port synchronous word RAM, block-RAM inferable.
// Latency: 1 cycle registered read; write visible to a read on the next cycle.
// Backpressure: none; write takes priority over read on the shared port.
// Ports: i_we/i_re enables, i_addr word address, i_wdata in, o_rdata registered out.
module imem_ram #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];

  // No reset: contents and read register survive reset by design.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else if (i_re) begin
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory for fetch plus byte-serial little-endian program loader.
// Latency: 1 cycle pc -> instruction; a loaded word is readable 1 cycle after its write.
// Backpressure: none on bytes; fetch held off via fetch_stall while not in RUN.
// Ports: clk, rst (async, active-high); bus = slave side of imem_loader_if
//   (pc/instruction/pc_misaligned/fetch_stall, load_mode/byte_valid/byte_data,
//    load_done/load_err/words_loaded).
module imem_loader
  import imem_pkg::*;
#(
  parameter int          ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter logic [31:0] NOP_WORD   = NOP_WORD_DEF
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);

  state_t              r_state;
  osel_t               r_osel;
  logic [1:0]          r_byte_cnt;
  logic [23:0]         r_asm;       // lanes 0..2; lane 3 goes straight to the RAM
  logic [ADDR_WIDTH:0] r_words;     // also serves as the write pointer
  logic                r_load_err;
  logic                r_load_done;
  logic                r_fetch_stall;
  logic                r_pc_misaligned;

  state_t                w_next;
  logic                  w_word_done;
  logic                  w_full;
  logic                  w_we;
  logic                  w_re;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [31:0]           w_rdata;
  logic                  w_unused_pc;

  assign w_unused_pc = ^bus.pc[31:ADDR_WIDTH+2];

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN:  if (bus.load_mode)  w_next = ST_LOAD;
      ST_LOAD: if (!bus.load_mode) w_next = ST_DONE;
      default: w_next = ST_RUN;
    endcase
  end

  // A byte arriving on the same edge load_mode falls is ignored.
  assign w_word_done = (r_state == ST_LOAD) && bus.load_mode && bus.byte_valid &&
                       (r_byte_cnt == 2'd3);
  // Count never exceeds depth, so the top bit alone flags a full memory.
  assign w_full      = r_words[ADDR_WIDTH];
  assign w_we        = w_word_done && !w_full;
  // Read only on edges that land in RUN (including DONE -> RUN), so the
  // first unstalled cycle already presents a real instruction.
  assign w_re        = (w_next == ST_RUN);
  assign w_addr      = w_we ? r_words[ADDR_WIDTH-1:0] : bus.pc[ADDR_WIDTH+1:2];

  imem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_addr),
    .i_wdata ({bus.byte_data, r_asm}),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_RUN;
      r_osel          <= OSEL_ZERO;
      r_byte_cnt      <= 2'd0;
      r_asm           <= 24'd0;
      r_words         <= '0;
      r_load_err      <= 1'b0;
      r_load_done     <= 1'b0;
      r_fetch_stall   <= 1'b0;
      r_pc_misaligned <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_fetch_stall   <= (w_next != ST_RUN);
      r_load_done     <= (w_next == ST_DONE);
      r_pc_misaligned <= w_re && (bus.pc[1:0] != 2'd0);
      r_osel          <= w_re ? OSEL_RAM : OSEL_NOP;

      case (r_state)
        ST_RUN: begin
          if (bus.load_mode) begin
            r_byte_cnt <= 2'd0;
            r_words    <= '0;
            r_load_err <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (!bus.load_mode) begin
            r_byte_cnt <= 2'd0;
            if (r_byte_cnt != 2'd0) r_load_err <= 1'b1;  // partial word dropped
          end else if (bus.byte_valid) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0: r_asm[7:0]   <= bus.byte_data;
              2'd1: r_asm[15:8]  <= bus.byte_data;
              2'd2: r_asm[23:16] <= bus.byte_data;
              default: begin
                if (w_full) r_load_err <= 1'b1;          // overflow: word dropped
                else        r_words    <= r_words + (ADDR_WIDTH+1)'(1);
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.instruction = 32'd0;
    case (r_osel)
      OSEL_RAM: bus.instruction = w_rdata;
      OSEL_NOP: bus.instruction = NOP_WORD;
      default:  bus.instruction = 32'd0;
    endcase
  end

  assign bus.pc_misaligned = r_pc_misaligned;
  assign bus.fetch_stall   = r_fetch_stall;
  assign bus.load_done     = r_load_done;
  assign bus.load_err      = r_load_err;
  assign bus.words_loaded  = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader against a word-level memory model.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_imem_loader;
  import imem_pkg::*;

  typedef logic [7:0] bq_t[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(14)) bus_a ();
  imem_loader_if #(.ADDR_WIDTH(2))  bus_b ();

  imem_loader #(.ADDR_WIDTH(14), .NOP_WORD(NOP)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  imem_loader #(.ADDR_WIDTH(2),  .NOP_WORD(NOP)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  int total = 0;
  int bad   = 0;

  logic [31:0] m_a [int];
  logic [31:0] m_b [int];

  logic [31:0] o_instr;
  logic        o_mis, o_stall, o_done, o_err;
  logic [14:0] o_words;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample(input bit b);
    if (b) begin
      o_instr = bus_b.instruction; o_mis = bus_b.pc_misaligned; o_stall = bus_b.fetch_stall;
      o_done  = bus_b.load_done;   o_err = bus_b.load_err;      o_words = {12'd0, bus_b.words_loaded};
    end else begin
      o_instr = bus_a.instruction; o_mis = bus_a.pc_misaligned; o_stall = bus_a.fetch_stall;
      o_done  = bus_a.load_done;   o_err = bus_a.load_err;      o_words = bus_a.words_loaded;
    end
  endtask

  task automatic step(input bit b, input logic lm, input logic bv, input logic [7:0] bd,
                      input logic [31:0] pc);
    if (b) begin
      bus_b.load_mode = lm; bus_b.byte_valid = bv; bus_b.byte_data = bd; bus_b.pc = pc;
    end else begin
      bus_a.load_mode = lm; bus_a.byte_valid = bv; bus_a.byte_data = bd; bus_a.pc = pc;
    end
    @(posedge clk);
    #1;
    sample(b);
  endtask

  // Whole-load reference: completed words land at 0,1,2..., capped at depth.
  task automatic do_load(input bit b, input bq_t q, input bit gaps);
    int depth, nw, keep;
    logic experr;
    depth  = b ? 4 : (1 << 14);
    nw     = q.size() / 4;
    keep   = (nw > depth) ? depth : nw;
    experr = ((q.size() % 4) != 0) || (nw > depth);
    for (int i = 0; i < keep; i++) begin
      if (b) m_b[i] = {q[4*i+3], q[4*i+2], q[4*i+1], q[4*i]};
      else   m_a[i] = {q[4*i+3], q[4*i+2], q[4*i+1], q[4*i]};
    end
    step(b, 1'b1, 1'b0, 8'h00, $urandom);
    check("load_entry_stall", 32'(o_stall), 32'd1);
    check("load_entry_err",   32'(o_err),   32'd0);
    check("load_entry_words", 32'(o_words), 32'd0);
    foreach (q[i]) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        step(b, 1'b1, 1'b0, 8'($urandom), $urandom);
        check("gap_stall", 32'(o_stall), 32'd1);
        check("gap_nop",   o_instr,      NOP);
      end
      step(b, 1'b1, 1'b1, q[i], $urandom);
      check("load_stall", 32'(o_stall), 32'd1);
      check("load_nop",   o_instr,      NOP);
      check("load_mis",   32'(o_mis),   32'd0);
    end
    // A byte strobed on the falling edge of load_mode must be ignored.
    step(b, 1'b0, 1'($urandom), 8'($urandom), $urandom);
    check("done_pulse", 32'(o_done),  32'd1);
    check("done_stall", 32'(o_stall), 32'd1);
    check("done_words", 32'(o_words), 32'(keep));
    check("done_err",   32'(o_err),   32'(experr));
    step(b, 1'b0, 1'b0, 8'h00, 32'd0);
    check("post_done",  32'(o_done),  32'd0);
    check("post_stall", 32'(o_stall), 32'd0);
  endtask

  task automatic fetch(input bit b, input logic [31:0] pc);
    int idx;
    step(b, 1'b0, 1'b0, 8'h00, pc);
    idx = b ? int'(pc[3:2]) : int'(pc[15:2]);
    check("fetch_stall", 32'(o_stall), 32'd0);
    check("fetch_mis",   32'(o_mis),   32'(pc[1:0] != 2'd0));
    if (b ? m_b.exists(idx) : m_a.exists(idx))
      check("fetch_word", o_instr, b ? m_b[idx] : m_a[idx]);
  endtask

  initial begin
    bq_t q;
    bus_a.load_mode = 0; bus_a.byte_valid = 0; bus_a.byte_data = 0; bus_a.pc = 0;
    bus_b.load_mode = 0; bus_b.byte_valid = 0; bus_b.byte_data = 0; bus_b.pc = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sample(0);
    check("rst_instr", o_instr,       32'd0);
    check("rst_mis",   32'(o_mis),    32'd0);
    check("rst_stall", 32'(o_stall),  32'd0);
    check("rst_done",  32'(o_done),   32'd0);
    check("rst_err",   32'(o_err),    32'd0);
    check("rst_words", 32'(o_words),  32'd0);
    rst = 1'b0;

    // Two-word program, pc toggling during load.
    q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h20, 8'h00};
    do_load(0, q, 0);
    check("tp1_words", 32'(o_words), 32'd2);
    check("tp1_err",   32'(o_err),   32'd0);
    fetch(0, 32'd0);
    check("tp1_w0", o_instr, 32'h0000_0013);
    fetch(0, 32'd4);
    check("tp1_w1", o_instr, 32'h0020_00B3);

    // Five bytes: one word, partial dropped, word 1 untouched.
    q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    do_load(0, q, 0);
    check("tp3_words", 32'(o_words), 32'd1);
    check("tp3_err",   32'(o_err),   32'd1);
    fetch(0, 32'd4);
    check("tp3_w1", o_instr, 32'h0020_00B3);
    fetch(0, 32'd0);
    check("tp3_w0", o_instr, 32'hDDCC_BBAA);
    check("tp3_err_sticky", 32'(o_err), 32'd1);

    // Reset in the middle of a load.
    step(0, 1'b1, 1'b0, 8'h00, 32'd0);
    check("rl_err_cleared", 32'(o_err), 32'd0);
    step(0, 1'b1, 1'b1, 8'h11, 32'd0);
    step(0, 1'b1, 1'b1, 8'h22, 32'd0);
    rst = 1'b1;
    #1;
    sample(0);
    check("rl_stall", 32'(o_stall), 32'd0);
    check("rl_instr", o_instr,       32'd0);
    check("rl_words", 32'(o_words),  32'd0);
    bus_a.load_mode = 1'b0; bus_a.byte_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fetch(0, 32'd4);
    check("rl_w1_kept", o_instr, 32'h0020_00B3);

    // Misaligned pc and ignored upper pc bits.
    fetch(0, 32'd6);
    check("mis_word", o_instr,    32'h0020_00B3);
    check("mis_flag", 32'(o_mis), 32'd1);
    fetch(0, 32'h8001_0004);
    check("hi_pc_word", o_instr, 32'h0020_00B3);

    // Overflow on the 4-word instance.
    q = {};
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
    do_load(1, q, 0);
    check("ovf_words", 32'(o_words), 32'd4);
    check("ovf_err",   32'(o_err),   32'd1);
    for (int i = 0; i < 4; i++) fetch(1, 32'(4 * i));
    fetch(1, 32'd0);
    check("ovf_no_wrap", o_instr, {q[3], q[2], q[1], q[0]});

    // Random loads with gaps, followed by random fetches.
    for (int n = 0; n < 15; n++) begin
      q = {};
      for (int i = 0, len = $urandom_range(0, 24); i < len; i++) q.push_back(8'($urandom));
      do_load(0, q, 1);
      for (int k = 0; k < 4; k++) fetch(0, {$urandom_range(0, 65535), $urandom_range(0, 7), 2'($urandom)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory responder for the fetch stage: returns the 32-bit instruction word addressed by the fetch unit's `PC`, and accepts a byte-serial program image (from the UART receiver) that it assembles into little-endian words and writes into memory. It sits between the fetch stage and the board-level program loader. Fetch is stalled while a program load is in progress.

## Interface
Parameters:
- `ADDR_WIDTH`, 14: word-address width; memory depth = 2**ADDR_WIDTH words.
- `NOP_WORD`, 32'h00000013: word driven on `instruction` while not in RUN.

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc`  in  32  byte address from fetch stage.
- `instruction`  out  32  registered instruction word.
- `pc_misaligned`  out  1  registered; `pc[1:0]` was nonzero.
- `fetch_stall`  out  1  registered; high while state is not RUN.
- `load_mode`  in  1  level; high requests or holds a program load.
- `byte_valid`  in  1  one-cycle strobe, `byte_data` valid.
- `byte_data`  in  8  program byte, little-endian order within a word.
- `load_done`  out  1  one-cycle pulse at end of load.
- `load_err`  out  1  sticky until next load starts: partial word or overflow.
- `words_loaded`  out  ADDR_WIDTH+1  count of words written in current/last load.

## Operation
- States: RUN, LOAD, DONE. Reset state RUN.
- RUN: memory read at word index `pc[ADDR_WIDTH+1:2]`; upper `pc` bits ignored. `load_mode`=1 → LOAD; on entry clear write pointer, byte counter, `words_loaded`, `load_err`.
- LOAD: each `byte_valid` stores `byte_data` into assembly-register lane `byte_cnt` (lane 0 = bits 7:0). On the 4th byte (`byte_cnt`=3), the full word, including the current byte, is written at the write pointer; pointer and `words_loaded` increment; `byte_cnt` wraps to 0.
- Overflow: a completed word arriving with `words_loaded` = 2**ADDR_WIDTH is dropped, sets `load_err`, and leaves the count unchanged.
- `load_mode` falling in LOAD → DONE. A nonzero `byte_cnt` at that point discards the partial word and sets `load_err`. A `byte_valid` in the same cycle as the fall is ignored.
- DONE: lasts exactly one cycle with `load_done`=1, then → RUN regardless of `load_mode`. A new load requires `load_mode` to be sampled high again in RUN.
- Outside RUN: `instruction` = `NOP_WORD`, `pc_misaligned`=0, `fetch_stall`=1. No memory reads are used.
- `rst` mid-load: returns to RUN immediately; all counters and flags clear; words already written are retained. Memory contents are never cleared by reset.

## Timing
- Reset values: `instruction`=0, `pc_misaligned`=0, `fetch_stall`=0, `load_done`=0, `load_err`=0, `words_loaded`=0.
- Read latency 1: `pc` sampled at edge t → `instruction`/`pc_misaligned` valid after edge t. The fetch stage updates `pc` on the falling edge, so the word is ready within the same CPU cycle.
- Write: a word is visible to a read one cycle after its write edge. Reads and writes never overlap because fetch is blocked during LOAD.
- `fetch_stall` rises the cycle after `load_mode` is first sampled high and falls the cycle after DONE.

## Structure
- Shared package `imem_pkg`: state encoding (RUN/LOAD/DONE), `NOP_WORD`, default `ADDR_WIDTH`.
- One sub-module `imem_ram`: single-port synchronous RAM (write enable, word address, 32-bit data in/out, registered read), inferable as block RAM.
- FSM, byte assembler, write pointer, and output muxing live in the top level.

## Test plan
- Load bytes 13,00,00,00,B3,00,20,00 then drop `load_mode` → `words_loaded`=2, one `load_done` pulse, `load_err`=0. Fetch `pc`=0 then 4 → `instruction` 0x00000013 then 0x002000B3, one cycle each.
- During LOAD, with `pc` toggling → `fetch_stall`=1 and `instruction`=0x00000013 every cycle.
- Load 5 bytes, then drop `load_mode` → `words_loaded`=1, `load_err`=1, word 1 unchanged.
- Assert `rst` after 2 bytes of a second load → RUN next cycle, all outputs at reset values, fetch `pc`=4 still returns 0x002000B3.
- Fetch `pc`=6 → returns word 1 with `pc_misaligned`=1.
- With `ADDR_WIDTH`=2, load 5 full words → first 4 written, `words_loaded`=4, `load_err`=1.
